// File: rtl/amba_apb_pkg.sv
// amba_apb_pkg: shared state type and default widths for the APB completer
package amba_apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
endpackage

// File: rtl/amba_apb_regfile.sv
// amba_apb_regfile: register array with one sync write port, async read port and async clear
module amba_apb_regfile
  import amba_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/amba_apb.sv
// amba_apb: APB completer with configurable wait states fronting a byte register file
module amba_apb
  import amba_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_W,
  parameter int DATA_WIDTH  = APB_DATA_W,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  apb_state_t state, state_nxt, phase;
  logic [3:0] count;
  logic [DATA_WIDTH-1:0] rdata;
  // SETUP is the first bus cycle of a transfer, recognised directly from the bus
  always_comb begin
    phase = (state == ACCESS) ? ACCESS : (PSEL && !PENABLE) ? SETUP : IDLE;
    PREADY = (state == ACCESS) && PSEL && PENABLE && (count == WS);
    state_nxt = (phase == SETUP) ? ACCESS :
                (phase == ACCESS && PSEL && !PREADY) ? ACCESS : IDLE;
  end
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) begin
      state <= IDLE;
      count <= '0;
      PRDATA <= '0;
    end else begin
      state <= state_nxt;
      count <= (state == ACCESS) ? count + 4'd1 : '0;
      if (phase == SETUP && !PWRITE) PRDATA <= rdata;
    end
  amba_apb_regfile #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clk  (PCLK),
    .rst_n(PRESET),
    .we   (PREADY && PWRITE),
    .waddr(PADDR),
    .wdata(PWDATA),
    .raddr(PADDR),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_amba_apb.sv
// tb_amba_apb: randomized self-checking bench for amba_apb with 0 and 3 wait states
module tb_amba_apb;
  logic       PCLK = 0;
  logic       PRESET;
  logic       psel[2], penable[2], pwrite[2], pready[2];
  logic [7:0] paddr[2], pwdata[2], prdata[2];
  logic [7:0] model[2][256];
  logic [7:0] last_rd[2];
  int         checks = 0;
  int         errors = 0;

  always #5 PCLK = ~PCLK;

  amba_apb #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(0)) u0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable[0]), .PADDR(paddr[0]),
    .PWRITE(pwrite[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]));
  amba_apb #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(3)) u3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable[1]), .PADDR(paddr[1]),
    .PWRITE(pwrite[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]));

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = 8'h00;
      for (int a = 0; a < 256; a++) model[i][a] = 8'h00;
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // one full transfer; entered and left 1 time unit after a rising edge
  task automatic xfer(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d);
    int ws = (i == 1) ? 3 : 0;
    psel[i] = 1'b1;
    penable[i] = 1'b0;
    pwrite[i] = wr;
    paddr[i] = a;
    pwdata[i] = d;
    @(negedge PCLK);
    checks++;
    if (pready[i] !== 1'b0) begin
      errors++;
      $display("FAIL setup_pready inst%0d got %b exp 0", i, pready[i]);
    end
    step();
    penable[i] = 1'b1;
    if (!wr) last_rd[i] = model[i][a];
    for (int c = 0; c <= ws; c++) begin
      @(negedge PCLK);
      checks++;
      if (pready[i] !== 1'(c == ws)) begin
        errors++;
        $display("FAIL access_pready inst%0d cyc%0d got %b exp %b", i, c, pready[i], c == ws);
      end
      checks++;
      if (prdata[i] !== last_rd[i]) begin
        errors++;
        $display("FAIL prdata inst%0d addr %h wr %0d got %h exp %h", i, a, wr, prdata[i], last_rd[i]);
      end
      step();
    end
    if (wr) model[i][a] = d;
    psel[i] = 1'b0;
    penable[i] = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 0; penable[i] = 0; pwrite[i] = 0; paddr[i] = 0; pwdata[i] = 0;
    end
    clear_model();
    repeat (2) step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (prdata[i] !== 8'h00 || pready[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d got %h/%b exp 00/0", i, prdata[i], pready[i]);
      end
    end
    PRESET = 1'b1;
    step();
    for (int k = 0; k < 4; k++) xfer(k % 2, 1'b0, 8'($urandom), 8'h00);
  endtask

  task automatic test_write_read();
    xfer(0, 1'b1, 8'h01, 8'h05);
    step();
    xfer(0, 1'b0, 8'h01, 8'h00);
    xfer(0, 1'b1, 8'h02, 8'h07);
    step();
    xfer(0, 1'b0, 8'h02, 8'h00);
    xfer(0, 1'b0, 8'h01, 8'h00);
  endtask

  task automatic test_wait_states();
    xfer(1, 1'b1, 8'h40, 8'h9E);
    step();
    xfer(1, 1'b0, 8'h40, 8'h00);
    xfer(1, 1'b1, 8'h41, 8'h61);
    xfer(1, 1'b0, 8'h41, 8'h00);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      xfer(i, 1'b1, 8'h10, 8'hAA);
      xfer(i, 1'b0, 8'h10, 8'h00);
      xfer(i, 1'b1, 8'h10, 8'h55);
      xfer(i, 1'b1, 8'h11, 8'h3C);
      xfer(i, 1'b0, 8'h10, 8'h00);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      xfer(int'($urandom_range(0, 1)), 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
      if ($urandom_range(0, 2) == 0) step();
    end
  endtask

  task automatic test_idle_penable();
    xfer(0, 1'b1, 8'h30, 8'h3C);
    xfer(0, 1'b0, 8'h31, 8'h00);
    pwrite[0] = 1'b1;
    paddr[0] = 8'h30;
    pwdata[0] = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      psel[0] = (k >= 2);
      penable[0] = 1'b1;
      @(negedge PCLK);
      checks++;
      if (pready[0] !== 1'b0 || prdata[0] !== last_rd[0]) begin
        errors++;
        $display("FAIL idle_penable k%0d got %b/%h exp 0/%h", k, pready[0], prdata[0], last_rd[0]);
      end
      step();
    end
    psel[0] = 1'b0;
    penable[0] = 1'b0;
    step();
    xfer(0, 1'b0, 8'h30, 8'h00);
  endtask

  task automatic test_reset_abort();
    xfer(1, 1'b1, 8'h20, 8'h5A);
    xfer(1, 1'b0, 8'h20, 8'h00);
    xfer(0, 1'b1, 8'h20, 8'h5A);
    xfer(0, 1'b0, 8'h20, 8'h00);
    psel[1] = 1'b1;
    penable[1] = 1'b0;
    pwrite[1] = 1'b1;
    paddr[1] = 8'h20;
    pwdata[1] = 8'h33;
    step();
    penable[1] = 1'b1;
    @(negedge PCLK);
    #2 PRESET = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (prdata[i] !== 8'h00 || pready[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset inst%0d got %h/%b exp 00/0", i, prdata[i], pready[i]);
      end
    end
    clear_model();
    step();
    psel[1] = 1'b0;
    penable[1] = 1'b0;
    step();
    PRESET = 1'b1;
    step();
    xfer(1, 1'b0, 8'h20, 8'h00);
    xfer(0, 1'b0, 8'h20, 8'h00);
    xfer(0, 1'b0, 8'h01, 8'h00);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_back_to_back();
    test_random();
    test_idle_penable();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/amba_apb.md
# amba_apb

APB (AMBA 3) completer peripheral backed by a 256 x 8 register file. It decodes standard SETUP/ACCESS transfers from an APB requester and writes PWDATA into, or returns PRDATA from, the addressed byte. PREADY wait-state insertion is configurable. It sits on the peripheral bus behind the APB bridge as a simple scratch/config memory.

## Interface
- ADDR_WIDTH, 8, address width; register file depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, data width of each register and of PWDATA/PRDATA.
- WAIT_STATES, 0, number of extra ACCESS cycles with PREADY low before completion (0 to 15).
- Clocking: one clock; reset is asynchronous and active-low.
- PCLK  in  1  bus clock; all state changes on its rising edge.
- PRESET  in  1  asynchronous active-low reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  second/ACCESS phase indicator.
- PADDR  in  ADDR_WIDTH  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer-complete indicator.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when PSEL=1, PENABLE=0.
  - SETUP -> ACCESS when PSEL=1, PENABLE=1.
  - SETUP -> IDLE when PSEL=0. This is a protocol violation; no transfer occurs.
  - ACCESS waits while PREADY=0.
  - When PREADY=1, ACCESS -> SETUP if PSEL=1 and PENABLE=0 (back-to-back transfer), otherwise ACCESS -> IDLE.
- PENABLE=1 while in IDLE is ignored: no write, no read load.
- Wait counter:
  - Cleared on entry to ACCESS and increments each ACCESS cycle.
  - PREADY = (state==ACCESS) & PSEL & PENABLE & (count==WAIT_STATES).
  - PREADY is a combinational decode of registered state/counter and is low in all other states.
- Write: mem[PADDR] <= PWDATA on the rising edge where PSEL & PENABLE & PWRITE & PREADY. Exactly one write per transfer.
- Read:
  - On the SETUP->ACCESS edge with PWRITE=0, PRDATA <= mem[PADDR].
  - PRDATA holds that value through ACCESS and afterwards until the next read load.
  - Writes never change PRDATA.
- PADDR, PWRITE and PWDATA are sampled in ACCESS and must be held stable by the requester from SETUP through completion.
- Reset (PRESET=0, any time, including mid-transfer):
  - State -> IDLE, counter -> 0.
  - PRDATA -> 0, PREADY -> 0.
  - All memory bytes -> 0.
  - An in-flight write is discarded.

## Timing
- With WAIT_STATES=0 every transfer takes 2 cycles (SETUP + ACCESS). PREADY is high in the first ACCESS cycle.
- With WAIT_STATES=N the ACCESS phase lasts N+1 cycles. PREADY is high only in the last one.
- Write data is visible to a read whose SETUP starts on the cycle immediately after the write completes.
- Read data is valid on PRDATA from the first ACCESS cycle.
- Reset assertion takes effect immediately, with no clock required.
- Operation resumes at the first rising PCLK after PRESET returns high.

## Structure
- Package amba_apb_pkg holds:
  - state enum apb_state_t {IDLE, SETUP, ACCESS};
  - default width constants APB_ADDR_W=8 and APB_DATA_W=8.
- Sub-module amba_apb_regfile contains the 2**ADDR_WIDTH x DATA_WIDTH array:
  - one synchronous write port (we, waddr, wdata);
  - one asynchronous read port;
  - asynchronous active-low clear.
- Top level holds the FSM, wait counter, PREADY decode and PRDATA register.

## Test plan
- Reset: hold PRESET=0 for 2 cycles -> PRDATA=0, PREADY=0, state IDLE. A read of any address after reset returns 0x00.
- Write then read, WAIT_STATES=0: write 0x05 to address 0x01 (SETUP, ACCESS, then PSEL=0) -> PREADY=1 in the ACCESS cycle. Read of address 0x01 -> PRDATA=0x05 in its ACCESS cycle.
- Second location: write 0x07 to address 0x02, then read address 0x02 -> 0x07. Read address 0x01 -> still 0x05.
- Wait states, WAIT_STATES=3: a write -> PREADY low for 3 ACCESS cycles and high on the 4th. The memory updates only on that 4th edge.
- Back-to-back transfers: write 0xAA to address 0x10, followed directly by a SETUP reading address 0x10 (no IDLE between) -> read returns 0xAA.
- Abort and violations:
  - Assert PRESET=0 during the ACCESS of a write of 0x33 to address 0x20 -> address 0x20 reads 0x00.
  - Drive PENABLE=1 with PSEL=0 -> no memory change.
